// File: rtl/key_pulse_array_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// key_pkg : shared defaults and helpers for the key_pulse_array slice
// Revision: 1.0
// ============================================================================
package key_pkg;

  localparam int   KEY_N_DEFAULT        = 4;
  localparam int   KEY_SYNC_DEFAULT     = 2;
  localparam int   KEY_DEBOUNCE_DEFAULT = 4;
  localparam logic HELD_RESET           = 1'b1;

  function automatic int cnt_w(input int n);
    return $clog2((n > 2) ? n : 2);
  endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_pulse_array_channel.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// key_channel : one key lane - synchroniser, stable-count debounce, press pulse
// Optional auto-repeat built when AUTO_REPEAT_EN is defined.  Revision: 1.0
// ============================================================================
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES   = KEY_SYNC_DEFAULT,
  parameter int DEBOUNCE_CYC  = KEY_DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_pulse,
  output logic o_held
);

  localparam int c_cnt_w = cnt_w(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_held;
  logic                   r_pulse;
  logic                   w_s;
  logic                   w_flip;
  logic                   w_rep_fire;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_flip = (w_s != r_held) && (r_cnt == c_cnt_w'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_held  <= HELD_RESET;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_key};
      r_pulse <= (w_flip & w_s) | w_rep_fire;
      if (w_s == r_held) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_held <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int c_rc_w =
    $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [c_rc_w-1:0] r_rc;
  logic              r_armed;

  // Only a genuine debounced press arms repeats, so a reset-held key stays quiet.
  assign w_rep_fire = r_armed && r_held && !w_flip && (r_rc == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc    <= '0;
      r_armed <= 1'b0;
    end else if (w_flip) begin
      r_armed <= w_s;
      r_rc    <= w_s ? c_rc_w'(REPEAT_DELAY - 1) : '0;
    end else if (!r_held) begin
      r_rc    <= '0;
      r_armed <= 1'b0;
    end else if (r_armed) begin
      r_rc <= (r_rc == '0) ? c_rc_w'(REPEAT_PERIOD - 1) : r_rc - 1'b1;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign w_rep_fire   = 1'b0;
`endif

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule : key_channel
`default_nettype wire

// File: rtl/key_pulse_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// key_pulse_array : N debounced key lanes with press pulses and held levels
// Optional auto-repeat via AUTO_REPEAT_EN.  Revision: 1.0
// ============================================================================
module key_pulse_array
  import key_pkg::*;
#(
  parameter int N_KEYS        = KEY_N_DEFAULT,
  parameter int SYNC_STAGES   = KEY_SYNC_DEFAULT,
  parameter int DEBOUNCE_CYC  = KEY_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] Key,
  output logic [N_KEYS-1:0] Out,
  output logic [N_KEYS-1:0] Held,
  output logic              AnyOut
);

  logic [N_KEYS-1:0] w_key;

  assign w_key  = (ACTIVE_LOW != 0) ? ~Key : Key;
  assign AnyOut = |Out;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk    (clock),
      .rst    (reset),
      .i_key  (w_key[gi]),
      .o_pulse(Out[gi]),
      .o_held (Held[gi])
    );
  end : g_ch

endmodule : key_pulse_array
`default_nettype wire
